axi4_video_frame_sched: RTL

//   Paces an upstream AXI4-Stream video source into the HDMI TX AXI4-video-to-HV converter path.

---
 rtl/axi4_stream_if.sv | 45 ++++
 rtl/axi4_video_frame_sched.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_stream_if.sv
// -----------------------------------------------------------------------------
// axi4_stream_if
//   AXI4-Stream video bundle shared by the frame scheduler and its neighbours.
//   One beat carries one pixel (three colour components packed into tdata).
//
// Signals
//   tdata  [DW-1:0]  pixel data
//   tvalid           source has a beat
//   tready           sink accepts the beat this cycle
//   tuser            start of frame (first pixel of the first line)
//   tlast            end of line (last pixel of every line)
//
// Modports
//   master : drives tdata/tvalid/tuser/tlast, samples tready
//   slave  : samples tdata/tvalid/tuser/tlast, drives tready
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface axi4_stream_if #(
  parameter int DW = 30
) ();

  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic          tuser;
  logic          tlast;

  modport master (
    output tdata,
    output tvalid,
    output tuser,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tuser,
    input  tlast,
    output tready
  );

endinterface : axi4_stream_if

// File: rtl/axi4_video_frame_sched.sv
// -----------------------------------------------------------------------------
// axi4_video_frame_sched
//   Paces an upstream AXI4-Stream video source into the AXI4-video-to-HV
//   converter path. The scheduler locks to start-of-frame (tuser), forwards
//   exactly X_RES x Y_RES beats per frame, and inserts H_BLANK idle cycles
//   after every line plus a vertical blanking interval after every frame.
//   tuser/tlast on the output are regenerated from internal counters, so a
//   sloppy source cannot corrupt the converter's framing.
//
// Ports
//   clk_i        in   clock, single domain
//   rst_i        in   synchronous, active-high reset
//   en_i         in   scheduler enable; only looked at while waiting for SOF
//   video_i      if   axi4_stream_if.slave, upstream pixels
//   video_o      if   axi4_stream_if.master, to converter (its tready is
//                     ignored: the converter is always ready)
//   err_o        out  one-cycle pulse on a framing error
//   underrun_o   out  one-cycle pulse per ACTIVE cycle with no input beat
//   frame_cnt_o  out  completed-frame counter, wraps at 16 bits
//
// Output timing: every output except video_i.tready is registered, so a beat
// accepted on edge N appears on video_o (and any error/underrun it causes on
// err_o/underrun_o) right after edge N.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module axi4_video_frame_sched #(
  parameter int X_RES    = 1920,
  parameter int Y_RES    = 1080,
  parameter int PX_WIDTH = 10,
  parameter int H_BLANK  = 280,
  parameter int V_BLANK  = 45
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  axi4_stream_if.slave  video_i,
  axi4_stream_if.master video_o,
  output logic          err_o,
  output logic          underrun_o,
  output logic [15:0]   frame_cnt_o
);

  // ---------------------------------------------------------------------------
  // Derived sizes
  // ---------------------------------------------------------------------------
  localparam int DW  = 3 * PX_WIDTH;
  localparam int PXW = $clog2(X_RES) + 1;
  localparam int LNW = $clog2(Y_RES) + 1;

  // Vertical blanking covers the trailing H_BLANK of the last line plus
  // V_BLANK full idle lines.
  localparam int VB_LEN = H_BLANK + V_BLANK * (X_RES + H_BLANK);

  // The blank counter spans the longest interval (VB_LEN >= H_BLANK).
  localparam int BW = (VB_LEN < 1) ? 1 : $clog2(VB_LEN + 1);

  localparam logic [PXW-1:0] PX_LAST = PXW'(X_RES - 1);
  localparam logic [LNW-1:0] LN_LAST = LNW'(Y_RES - 1);
  localparam logic [BW-1:0]  HB_LAST = BW'((H_BLANK > 0) ? H_BLANK - 1 : 0);
  localparam logic [BW-1:0]  VB_LAST = BW'((VB_LEN  > 0) ? VB_LEN  - 1 : 0);

  typedef enum logic [1:0] {
    S_WAIT_SOF = 2'd0,
    S_ACTIVE   = 2'd1,
    S_HBLANK   = 2'd2,
    S_VBLANK   = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  state_t          r_state;
  logic [PXW-1:0]  r_px_cnt;
  logic [LNW-1:0]  r_ln_cnt;
  logic [BW-1:0]   r_blank_cnt;

  logic [DW-1:0]   r_tdata;
  logic            r_tvalid;
  logic            r_tuser;
  logic            r_tlast;
  logic            r_err;
  logic            r_underrun;
  logic [15:0]     r_frame_cnt;

  // ---------------------------------------------------------------------------
  // Next-state / decode wires
  // ---------------------------------------------------------------------------
  state_t          w_state_nxt;
  logic [PXW-1:0]  w_px_nxt;
  logic [LNW-1:0]  w_ln_nxt;
  logic [BW-1:0]   w_blank_nxt;
  logic            w_tready;
  logic            w_accept;
  logic            w_frame_err;
  logic            w_frame_done;
  logic            w_underrun;

  logic            w_sof_pos;
  logic            w_px_last;
  logic            w_in_sof;

  assign w_sof_pos = (r_px_cnt == '0) && (r_ln_cnt == '0);
  assign w_px_last = (r_px_cnt == PX_LAST);
  assign w_in_sof  = video_i.tvalid && video_i.tuser;

  // ---------------------------------------------------------------------------
  // Next-state logic, tready and per-cycle events
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    w_state_nxt  = r_state;
    w_px_nxt     = r_px_cnt;
    w_ln_nxt     = r_ln_cnt;
    w_blank_nxt  = r_blank_cnt;
    w_tready     = 1'b0;
    w_accept     = 1'b0;
    w_frame_err  = 1'b0;
    w_frame_done = 1'b0;
    w_underrun   = 1'b0;

    unique case (r_state)
      S_WAIT_SOF: begin
        // Disabled: hold off the source entirely. Enabled: swallow anything
        // that is not SOF, and leave the SOF beat on the bus for ACTIVE.
        if (en_i) begin
          w_tready = !w_in_sof;
          if (w_in_sof) begin
            w_state_nxt = S_ACTIVE;
            w_px_nxt    = '0;
            w_ln_nxt    = '0;
          end
        end
      end

      S_ACTIVE: begin
        if (w_in_sof && !w_sof_pos) begin
          // A new frame started early: leave the SOF beat unconsumed so
          // WAIT_SOF re-locks onto it on the very next cycle.
          w_frame_err = 1'b1;
          w_state_nxt = S_WAIT_SOF;
          w_px_nxt    = '0;
          w_ln_nxt    = '0;
        end else begin
          w_tready = 1'b1;
          if (!video_i.tvalid) begin
            w_underrun = 1'b1;
          end else begin
            w_accept = 1'b1;
            if (video_i.tlast != w_px_last) begin
              // Line length disagrees with X_RES: abandon the frame without
              // blanking and without counting it.
              w_frame_err = 1'b1;
              w_state_nxt = S_WAIT_SOF;
              w_px_nxt    = '0;
              w_ln_nxt    = '0;
            end else if (w_px_last) begin
              w_px_nxt    = '0;
              w_blank_nxt = '0;
              if (r_ln_cnt == LN_LAST) begin
                w_frame_done = 1'b1;
                w_ln_nxt     = '0;
                w_state_nxt  = (VB_LEN == 0) ? S_WAIT_SOF : S_VBLANK;
              end else begin
                w_ln_nxt    = r_ln_cnt + LNW'(1);
                w_state_nxt = (H_BLANK == 0) ? S_ACTIVE : S_HBLANK;
              end
            end else begin
              w_px_nxt = r_px_cnt + PXW'(1);
            end
          end
        end
      end

      S_HBLANK: begin
        if (r_blank_cnt == HB_LAST) begin
          w_blank_nxt = '0;
          w_state_nxt = S_ACTIVE;
        end else begin
          w_blank_nxt = r_blank_cnt + BW'(1);
        end
      end

      S_VBLANK: begin
        if (r_blank_cnt == VB_LAST) begin
          w_blank_nxt = '0;
          w_state_nxt = S_WAIT_SOF;
        end else begin
          w_blank_nxt = r_blank_cnt + BW'(1);
        end
      end

      default: begin
        w_state_nxt = S_WAIT_SOF;
      end
    endcase

    // Nothing may be consumed while reset is held.
    if (rst_i) begin
      w_tready = 1'b0;
      w_accept = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments throughout, so every register here
    // samples the values from before the edge regardless of statement order.
    if (rst_i) begin
      r_state     <= S_WAIT_SOF;
      r_px_cnt    <= '0;
      r_ln_cnt    <= '0;
      r_blank_cnt <= '0;
      // NOTE: the pixel data register is reset as well, because the converter
      // must see an all-zero bus straight out of reset, not stale pixels.
      r_tdata     <= '0;
      r_tvalid    <= 1'b0;
      r_tuser     <= 1'b0;
      r_tlast     <= 1'b0;
      r_err       <= 1'b0;
      r_underrun  <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_px_cnt    <= w_px_nxt;
      r_ln_cnt    <= w_ln_nxt;
      r_blank_cnt <= w_blank_nxt;

      r_tvalid    <= w_accept;
      if (w_accept) begin
        r_tdata <= video_i.tdata;
      end
      // Framing on the output comes from our counters; an early input tlast
      // still closes the line so the converter never sees an open line.
      r_tuser     <= w_accept && w_sof_pos;
      r_tlast     <= w_accept && (w_px_last || video_i.tlast);

      r_err       <= w_frame_err;
      r_underrun  <= w_underrun;
      if (w_frame_done) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign video_i.tready = w_tready;

  assign video_o.tdata  = r_tdata;
  assign video_o.tvalid = r_tvalid;
  assign video_o.tuser  = r_tuser;
  assign video_o.tlast  = r_tlast;

  assign err_o          = r_err;
  assign underrun_o     = r_underrun;
  assign frame_cnt_o    = r_frame_cnt;

endmodule : axi4_video_frame_sched
